// File: rtl/pnm_pkg.sv
// Shared definitions for the PNM pooling path: FP32 constants and the
// stream-controller FSM state encoding.
package pnm_pkg;

    localparam int unsigned FP32_W        = 32;
    localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVEN_ROW = 2'd1,
        ODD_ROW  = 2'd2,
        DRAIN    = 2'd3
    } pool_state_t;

endpackage

// File: rtl/fp_max_pool_2x2.sv
// Combinational FP32 maximum of one 2x2 window.
// Ordering comes from fp_gt: NaN never compares greater, +0 and -0 are equal,
// and on a tie the earlier operand (raster order a, b, c, d) is kept.
module fp_max_pool_2x2
    import pnm_pkg::*;
(
    input  logic [FP32_W-1:0] i_a,
    input  logic [FP32_W-1:0] i_b,
    input  logic [FP32_W-1:0] i_c,
    input  logic [FP32_W-1:0] i_d,
    output logic [FP32_W-1:0] o_max
);

    function automatic logic fp_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    endfunction

    // Strict IEEE "x > y"; any NaN operand yields false.
    function automatic logic fp_gt(input logic [31:0] x, input logic [31:0] y);
        logic r;
        if (fp_is_nan(x) || fp_is_nan(y)) begin
            r = 1'b0;
        end else if ((x[30:0] == 31'h0) && (y[30:0] == 31'h0)) begin
            r = 1'b0;
        end else if (x[31] != y[31]) begin
            r = ~x[31];
        end else if (x[31] == 1'b0) begin
            r = (x[30:0] > y[30:0]);
        end else begin
            r = (x[30:0] < y[30:0]);
        end
        return r;
    endfunction

    logic [FP32_W-1:0] w_top;
    logic [FP32_W-1:0] w_bot;

    // Two-level compare tree: row maxima first, then the larger of the two.
    always_comb begin
        w_top = fp_gt(i_b, i_a) ? i_b : i_a;
        w_bot = fp_gt(i_d, i_c) ? i_d : i_c;
        o_max = fp_gt(w_bot, w_top) ? w_bot : w_top;
    end

endmodule

// File: rtl/max_pool_2x2_stream_ctrl.sv
// Stream controller for 2x2 FP32 max pooling over a raster-ordered map.
// Buffers each even row, pairs it with the following odd row and emits one
// pooled value per window through a single output register.
// Build option: define MAXPOOL_RELU_EN to clamp negative pooled results to +0.
module max_pool_2x2_stream_ctrl
    import pnm_pkg::*;
#(
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned DATA_W = 32
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned      COL_W    = $clog2(IMG_W);
    localparam int unsigned      ROW_W    = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    if (DATA_W != FP32_W) begin : g_bad_data_w
        $error("max_pool_2x2_stream_ctrl: DATA_W must be 32 (FP32)");
    end

    pool_state_t       r_state;
    pool_state_t       w_next_state;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [DATA_W-1:0] r_linebuf [IMG_W];
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_m_data;
    logic              r_m_valid;
    logic              r_done;
    logic              w_s_ready;
    logic              w_busy;
    logic              w_accept;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_load;
    logic [COL_W-1:0]  w_col_prev;
    logic [DATA_W-1:0] w_pool;
    logic [DATA_W-1:0] w_result;

    assign w_accept   = s_valid && w_s_ready;
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    assign w_col_prev = r_col - COL_W'(1);
    assign w_load     = w_accept && (r_state == ODD_ROW) && r_col[0];

    fp_max_pool_2x2 u_pool (
        .i_a   (r_linebuf[w_col_prev]),
        .i_b   (r_linebuf[r_col]),
        .i_c   (r_hold),
        .i_d   (s_data),
        .o_max (w_pool)
    );

    // Optional fused ReLU on the pooled value before it is registered.
    always_comb begin
`ifdef MAXPOOL_RELU_EN
        if (w_pool[DATA_W-1]) begin
            w_result = FP32_POS_ZERO;
        end else begin
            w_result = w_pool;
        end
`else
        w_result = w_pool;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; transitions out of the row states happen on the
    // accepted last pixel of a row.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_next_state = EVEN_ROW;
                else       w_next_state = IDLE;
            end
            EVEN_ROW: begin
                if (w_accept && w_col_last) w_next_state = ODD_ROW;
                else                        w_next_state = EVEN_ROW;
            end
            ODD_ROW: begin
                if (w_accept && w_col_last) begin
                    if (w_row_last) w_next_state = DRAIN;
                    else            w_next_state = EVEN_ROW;
                end else begin
                    w_next_state = ODD_ROW;
                end
            end
            DRAIN: begin
                if (!r_m_valid) w_next_state = IDLE;
                else            w_next_state = DRAIN;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // FSM outputs; the window-closing pixel is only taken when the output
    // register is free or being drained this cycle.
    always_comb begin
        w_s_ready = 1'b0;
        w_busy    = 1'b1;
        case (r_state)
            IDLE: begin
                w_s_ready = 1'b0;
                w_busy    = 1'b0;
            end
            EVEN_ROW: w_s_ready = 1'b1;
            ODD_ROW: begin
                if (r_col[0] == 1'b0) w_s_ready = 1'b1;
                else                  w_s_ready = !r_m_valid || m_ready;
            end
            DRAIN: w_s_ready = 1'b0;
            default: begin
                w_s_ready = 1'b0;
                w_busy    = 1'b0;
            end
        endcase
    end

    // Column/row counters: column wraps per row, row wraps at frame end.
    always_ff @(posedge clk) begin
        if (rst || (r_state == IDLE)) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                if (w_row_last) r_row <= '0;
                else            r_row <= r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Line buffer for the even row and the held even-column odd-row pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(IMG_W); i++) begin
                r_linebuf[i] <= '0;
            end
            r_hold <= '0;
        end else if (w_accept && (r_state == EVEN_ROW)) begin
            r_linebuf[r_col] <= s_data;
        end else if (w_accept && (r_state == ODD_ROW) && !r_col[0]) begin
            r_hold <= s_data;
        end
    end

    // Output register: a new load overrides a same-cycle drain, otherwise
    // data holds while valid is cleared on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_data  <= FP32_POS_ZERO;
        end else if (w_load) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_result;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    // One-cycle done pulse once the final output has left the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == DRAIN) && !r_m_valid;
        end
    end

    assign s_ready = w_s_ready;
    assign busy    = w_busy;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign done    = r_done;

endmodule

// File: tb/tb_max_pool_2x2_stream_ctrl.sv
// Directed bench for max_pool_2x2_stream_ctrl: a 4x4 instance for the
// handshake/reset/start cases and an 8x8 instance for a randomized frame.
module tb_max_pool_2x2_stream_ctrl;

    logic clk = 1'b0;
    logic rst;

    logic        start_a, s_valid_a, s_ready_a, m_valid_a, m_ready_a, busy_a, done_a;
    logic [31:0] s_data_a, m_data_a;
    logic        start_b, s_valid_b, s_ready_b, m_valid_b, m_ready_b, busy_b, done_b;
    logic [31:0] s_data_b, m_data_b;

    always #5 clk = ~clk;

    max_pool_2x2_stream_ctrl #(.IMG_W(4), .IMG_H(4), .DATA_W(32)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .s_valid(s_valid_a), .s_data(s_data_a),
        .s_ready(s_ready_a), .m_valid(m_valid_a), .m_data(m_data_a), .m_ready(m_ready_a),
        .busy(busy_a), .done(done_a)
    );

    max_pool_2x2_stream_ctrl #(.IMG_W(8), .IMG_H(8), .DATA_W(32)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .s_valid(s_valid_b), .s_data(s_data_b),
        .s_ready(s_ready_b), .m_valid(m_valid_b), .m_data(m_data_b), .m_ready(m_ready_b),
        .busy(busy_b), .done(done_b)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    int          done_cnt_a = 0;
    int          done_cnt_b = 0;
    int          rd_a = 0;
    int          done_exp = 0;
    logic [31:0] frame_inc [16];
    logic [31:0] frame_neg [16];
    logic [31:0] big [64];
    logic [31:0] exp_b [16];

    // Capture completed output transfers and done pulses between clock edges.
    always @(negedge clk) begin
        if (m_valid_a && m_ready_a) q_a.push_back(m_data_a);
        if (done_a) done_cnt_a++;
        if (m_valid_b && m_ready_b) q_b.push_back(m_data_b);
        if (done_b) done_cnt_b++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [31:0] d);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        s_valid_a = 1'b1;
        s_data_a  = d;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = s_ready_a;
            n++;
            tick();
        end
        s_valid_a = 1'b0;
        if (!acc) check("send_a_timeout", {31'b0, s_ready_a}, 32'd1);
    endtask

    task automatic start_frame_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        @(negedge clk);
        check("busy_after_start", {31'b0, busy_a}, 32'd1);
        tick();
    endtask

    task automatic wait_done_a();
        int n;
        n = 0;
        done_exp++;
        while (done_cnt_a < done_exp && n < 200) begin
            tick();
            n++;
        end
        check("done_count_a", 32'(done_cnt_a), 32'(done_exp));
    endtask

    task automatic check_q_a(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e [4];
        logic [31:0] obs;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int k = 0; k < 4; k++) begin
            obs = (rd_a < q_a.size()) ? q_a[rd_a] : 32'hDEAD_DEAD;
            check($sformatf("%s_out%0d", tag, k), obs, e[k]);
            rd_a++;
        end
        check($sformatf("%s_count", tag), 32'(q_a.size()), 32'(rd_a));
    endtask

    initial begin
        bit acc;
        int idx;
        int n;
        logic [31:0] m;
        logic [31:0] obs;

        frame_inc = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                      32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000,
                      32'h4110_0000, 32'h4120_0000, 32'h4130_0000, 32'h4140_0000,
                      32'h4150_0000, 32'h4160_0000, 32'h4170_0000, 32'h4180_0000};
        frame_neg = '{32'hBF80_0000, 32'hC040_0000, 32'h4000_0000, 32'hC080_0000,
                      32'hC000_0000, 32'hBF00_0000, 32'h4040_0000, 32'hBF80_0000,
                      32'hC000_0000, 32'hBF80_0000, 32'h3F80_0000, 32'h4000_0000,
                      32'hC080_0000, 32'hC040_0000, 32'h4040_0000, 32'h4080_0000};

        rst = 1'b1;
        start_a = 1'b0; s_valid_a = 1'b0; s_data_a = 32'h0; m_ready_a = 1'b1;
        start_b = 1'b0; s_valid_b = 1'b0; s_data_b = 32'h0; m_ready_b = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_s_ready", {31'b0, s_ready_a}, 32'd0);
        check("rst_m_valid", {31'b0, m_valid_a}, 32'd0);
        check("rst_m_data",  m_data_a, 32'h0);
        check("rst_busy",    {31'b0, busy_a}, 32'd0);
        check("rst_done",    {31'b0, done_a}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1: incrementing 4x4 frame, free-running sink
        start_frame_a();
        for (int i = 0; i < 16; i++) send_a(frame_inc[i]);
        wait_done_a();
        check_q_a("t1", 32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000);
        @(negedge clk);
        check("t1_busy_idle", {31'b0, busy_a}, 32'd0);
        tick();

        // 2: sink stalls 5 cycles after the first output
        start_frame_a();
        for (int i = 0; i < 6; i++) send_a(frame_inc[i]);
        m_ready_a = 1'b0;
        @(negedge clk);
        check("t2_m_valid", {31'b0, m_valid_a}, 32'd1);
        check("t2_hold0", m_data_a, 32'h40C0_0000);
        tick();
        send_a(frame_inc[6]);
        s_valid_a = 1'b1;
        s_data_a  = frame_inc[7];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("t2_s_ready_low%0d", k), {31'b0, s_ready_a}, 32'd0);
            check($sformatf("t2_hold%0d", k + 1), m_data_a, 32'h40C0_0000);
            tick();
        end
        m_ready_a = 1'b1;
        for (int i = 7; i < 16; i++) send_a(frame_inc[i]);
        wait_done_a();
        check_q_a("t2", 32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000);

        // 3: negative windows
        start_frame_a();
        for (int i = 0; i < 16; i++) send_a(frame_neg[i]);
        wait_done_a();
`ifdef MAXPOOL_RELU_EN
        check_q_a("t3", 32'h0000_0000, 32'h4040_0000, 32'h0000_0000, 32'h4080_0000);
`else
        check_q_a("t3", 32'hBF00_0000, 32'h4040_0000, 32'hBF80_0000, 32'h4080_0000);
`endif

        // 4: reset in the middle of an odd row with an output pending
        m_ready_a = 1'b0;
        start_frame_a();
        for (int i = 0; i < 6; i++) send_a(frame_inc[i]);
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("t4_m_valid", {31'b0, m_valid_a}, 32'd0);
        check("t4_m_data",  m_data_a, 32'h0);
        check("t4_busy",    {31'b0, busy_a}, 32'd0);
        check("t4_s_ready", {31'b0, s_ready_a}, 32'd0);
        tick();
        rst = 1'b0;
        m_ready_a = 1'b1;
        tick();
        start_frame_a();
        for (int i = 0; i < 16; i++) send_a(frame_inc[i]);
        wait_done_a();
        check_q_a("t4", 32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000);

        // 5: start pulsed mid-frame is ignored
        start_frame_a();
        for (int i = 0; i < 3; i++) send_a(frame_inc[i]);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        @(negedge clk);
        check("t5_busy", {31'b0, busy_a}, 32'd1);
        tick();
        for (int i = 3; i < 16; i++) send_a(frame_inc[i]);
        wait_done_a();
        check_q_a("t5", 32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000);
        repeat (5) tick();
        check("t5_done_once", 32'(done_cnt_a), 32'(done_exp));

        // 6: random 8x8 frame with source and sink gaps
        for (int i = 0; i < 64; i++) begin
            big[i] = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
        end
        for (int wr = 0; wr < 4; wr++) begin
            for (int wc = 0; wc < 4; wc++) begin
                m = big[(2 * wr) * 8 + 2 * wc];
                if (big[(2 * wr) * 8 + 2 * wc + 1] > m)     m = big[(2 * wr) * 8 + 2 * wc + 1];
                if (big[(2 * wr + 1) * 8 + 2 * wc] > m)     m = big[(2 * wr + 1) * 8 + 2 * wc];
                if (big[(2 * wr + 1) * 8 + 2 * wc + 1] > m) m = big[(2 * wr + 1) * 8 + 2 * wc + 1];
                exp_b[wr * 4 + wc] = m;
            end
        end
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        idx = 0;
        n = 0;
        while ((idx < 64 || done_cnt_b < 1) && n < 3000) begin
            s_valid_b = (idx < 64) && ($urandom_range(0, 3) != 0);
            s_data_b  = big[(idx < 64) ? idx : 63];
            m_ready_b = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc = s_valid_b && s_ready_b;
            tick();
            if (acc) idx++;
            n++;
        end
        s_valid_b = 1'b0;
        m_ready_b = 1'b1;
        check("t6_pixels", 32'(idx), 32'd64);
        check("t6_done", 32'(done_cnt_b), 32'd1);
        check("t6_count", 32'(q_b.size()), 32'd16);
        for (int k = 0; k < 16; k++) begin
            obs = (k < q_b.size()) ? q_b[k] : 32'hDEAD_DEAD;
            check($sformatf("t6_out%0d", k), obs, exp_b[k]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
